// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the multiplier-sharing arbiter:
//   - widths of the 32x32 signed multiplier datapath and its fixed latency
//   - tag_t: valid bit + requester ID carried alongside each operation
//   - rr_find_first: round-robin search used by the arbiter
// -----------------------------------------------------------------------------
package mult_pkg;

  localparam int MULT_LAT_32X32 = 32;
  localparam int DATA_W         = 32;
  localparam int PROD_W         = 64;

  // The ID field is sized for the largest supported requester count (8) so
  // that one tag type serves every legal N_REQ; unused upper ID bits stay 0.
  localparam int N_REQ_MAX = 8;
  localparam int ID_W_MAX  = 3;

  typedef struct packed {
    logic                valid;
    logic [ID_W_MAX-1:0] id;
  } tag_t;

  typedef struct packed {
    logic                found;
    logic [ID_W_MAX-1:0] id;
  } rr_pick_t;

  localparam tag_t TAG_IDLE = '{valid: 1'b0, id: 3'd0};

  // Scan requesters starting one past ptr, wrapping at n_req, and return the
  // first one with valid set. The wrap is done incrementally so no modulo
  // operator is needed.
  function automatic rr_pick_t rr_find_first(input logic [N_REQ_MAX-1:0] valid,
                                             input logic [ID_W_MAX-1:0]  ptr,
                                             input int                   n_req);
    rr_pick_t            pick;
    logic [ID_W_MAX-1:0] idx;
    pick.found = 1'b0;
    pick.id    = 3'd0;
    idx        = ptr;
    for (int k = 0; k < N_REQ_MAX; k++) begin
      if (k < n_req) begin
        idx = (idx == ID_W_MAX'(n_req - 1)) ? 3'd0 : idx + 3'd1;
        if (!pick.found && valid[idx]) begin
          pick.found = 1'b1;
          pick.id    = idx;
        end else begin
          pick = pick;
        end
      end else begin
        idx = idx;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/mult_tag_pipe.sv
// -----------------------------------------------------------------------------
// mult_tag_pipe
// Fixed-depth shift register of tag_t that travels in lockstep with the
// shared multiplier. Shifts every cycle unconditionally (the multiplier never
// stalls). A synchronous clear wipes every stage; busy_o reports whether any
// stage holds a valid tag.
// Ports:
//   clk_i   clock, rising edge
//   rst_ni  asynchronous active-low reset
//   clr_i   synchronous clear of all stages
//   tag_i   tag entering stage 0
//   tag_o   tag leaving the last stage
//   busy_o  1 when any stage is valid
// -----------------------------------------------------------------------------
module mult_tag_pipe
  import mult_pkg::*;
#(
  parameter int DEPTH = 33
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  tag_t tag_i,
  output tag_t tag_o,
  output logic busy_o
);

  tag_t stage_q [DEPTH];
  tag_t stage_d [DEPTH];
  logic busy_s;

  // Next-state: shift by one, or clear everything on clr_i.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      stage_d[k] = TAG_IDLE;
    end
    if (clr_i) begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_d[k] = TAG_IDLE;
      end
    end else begin
      stage_d[0] = tag_i;
      for (int k = 1; k < DEPTH; k++) begin
        stage_d[k] = stage_q[k-1];
      end
    end
  end

  // Stage registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_q[k] <= TAG_IDLE;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        stage_q[k] <= stage_d[k];
      end
    end
  end

  // Occupancy: OR of all stage valid bits.
  always_comb begin
    busy_s = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      busy_s = busy_s | stage_q[k].valid;
    end
  end

  assign tag_o  = stage_q[DEPTH-1];
  assign busy_o = busy_s;

endmodule

// File: rtl/mult_share_arb_32_32_2sc.sv
// -----------------------------------------------------------------------------
// mult_share_arb_32_32_2sc
// Round-robin arbiter and sequencer sharing one free-running pipelined 32x32
// signed multiplier among N_REQ requesters. The granted operands are
// registered onto mult_a/mult_b; a valid+ID tag follows the operation so the
// product returning on mult_y is steered to the requester that issued it.
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous active-low reset
//   req_valid  per-requester operand valid
//   req_ready  one-hot grant (transfer when valid & ready)
//   req_a/b    packed operands, requester i at [32i+31:32i]
//   flush      synchronous discard of all in-flight operations
//   mult_a/b   registered operands to the multiplier
//   mult_y     product from the multiplier
//   res_valid  one-hot result strobe
//   res_y      result (mult_y passthrough)
//   busy       1 when any tag stage is valid
// -----------------------------------------------------------------------------
module mult_share_arb_32_32_2sc
  import mult_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int ID_W     = 2,
  parameter int MULT_LAT = MULT_LAT_32X32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*DATA_W-1:0] req_a,
  input  logic [N_REQ*DATA_W-1:0] req_b,
  input  logic                    flush,
  output logic [DATA_W-1:0]       mult_a,
  output logic [DATA_W-1:0]       mult_b,
  input  logic [PROD_W-1:0]       mult_y,
  output logic [N_REQ-1:0]        res_valid,
  output logic [PROD_W-1:0]       res_y,
  output logic                    busy
);

  logic [ID_W-1:0]   ptr_q;
  logic [ID_W-1:0]   ptr_d;
  logic [DATA_W-1:0] mult_a_q;
  logic [DATA_W-1:0] mult_a_d;
  logic [DATA_W-1:0] mult_b_q;
  logic [DATA_W-1:0] mult_b_d;
  rr_pick_t          pick_s;
  logic              accept_s;
  tag_t              tag_in_s;
  tag_t              tag_out_s;

  // Arbitration: round-robin pick, suppressed while flushing.
  always_comb begin
    pick_s    = rr_find_first(N_REQ_MAX'(req_valid), ID_W_MAX'(ptr_q), N_REQ);
    req_ready = {N_REQ{1'b0}};
    if (!flush && pick_s.found) begin
      for (int i = 0; i < N_REQ; i++) begin
        req_ready[i] = (pick_s.id == ID_W_MAX'(i));
      end
    end else begin
      req_ready = {N_REQ{1'b0}};
    end
  end

  // Issue mux: AND-OR select of the granted operands; zero when idle so the
  // multiplier inputs stop toggling.
  always_comb begin
    accept_s = |req_ready;
    mult_a_d = {DATA_W{1'b0}};
    mult_b_d = {DATA_W{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      mult_a_d = mult_a_d | (req_a[i*DATA_W +: DATA_W] & {DATA_W{req_ready[i]}});
      mult_b_d = mult_b_d | (req_b[i*DATA_W +: DATA_W] & {DATA_W{req_ready[i]}});
    end
    if (accept_s) begin
      ptr_d          = pick_s.id[ID_W-1:0];
      tag_in_s.valid = 1'b1;
      tag_in_s.id    = pick_s.id;
    end else begin
      ptr_d          = ptr_q;
      tag_in_s       = TAG_IDLE;
    end
  end

  // Operand issue registers and round-robin pointer (pointer starts at the
  // last requester so requester 0 wins the first contested cycle).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mult_a_q <= {DATA_W{1'b0}};
      mult_b_q <= {DATA_W{1'b0}};
      ptr_q    <= ID_W'(N_REQ - 1);
    end else begin
      mult_a_q <= mult_a_d;
      mult_b_q <= mult_b_d;
      ptr_q    <= ptr_d;
    end
  end

  // Stage 0 of the tag pipe is loaded on the same edge as mult_a/mult_b, and
  // the product appears MULT_LAT cycles after that, so the tag needs
  // MULT_LAT+1 register stages to line up with mult_y.
  mult_tag_pipe #(
    .DEPTH (MULT_LAT + 1)
  ) u_tag_pipe (
    .clk_i  (clk),
    .rst_ni (reset),
    .clr_i  (flush),
    .tag_i  (tag_in_s),
    .tag_o  (tag_out_s),
    .busy_o (busy)
  );

  // Result steering: decode the returning tag; flush masks the strobe.
  always_comb begin
    res_valid = {N_REQ{1'b0}};
    if (tag_out_s.valid && !flush) begin
      for (int i = 0; i < N_REQ; i++) begin
        res_valid[i] = (tag_out_s.id == ID_W_MAX'(i));
      end
    end else begin
      res_valid = {N_REQ{1'b0}};
    end
  end

  assign res_y  = mult_y;
  assign mult_a = mult_a_q;
  assign mult_b = mult_b_q;

endmodule

// File: tb/tb_mult_share_arb_32_32_2sc.sv
module tb_mult_share_arb_32_32_2sc;

  localparam int N   = 4;
  localparam int LAT = 32;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*32-1:0] req_a;
  logic [N*32-1:0] req_b;
  logic           flush;
  logic [31:0]    mult_a;
  logic [31:0]    mult_b;
  logic [63:0]    mult_y;
  logic [N-1:0]   res_valid;
  logic [63:0]    res_y;
  logic           busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    logic [N-1:0] rv;
    logic [63:0]  y;
    int           due;
  } exp_t;
  exp_t exp_q[$];

  logic signed [63:0] mul_pipe [LAT];

  logic [31:0] ta [N];
  logic [31:0] tb [N];
  logic [63:0] ty [N];

  mult_share_arb_32_32_2sc dut (
    .clk       (clk),
    .reset     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .flush     (flush),
    .mult_a    (mult_a),
    .mult_b    (mult_b),
    .mult_y    (mult_y),
    .res_valid (res_valid),
    .res_y     (res_y),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Environment model of the unreset, fixed-latency signed multiplier.
  always @(posedge clk) begin
    mul_pipe[0] <= $signed(mult_a) * $signed(mult_b);
    for (int k = 1; k < LAT; k++) mul_pipe[k] <= mul_pipe[k-1];
  end
  assign mult_y = mul_pipe[LAT-1];

  // Monitor: every result strobe must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && res_valid !== 4'b0000) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL spurious_result: res_valid=%b res_y=%h at cycle %0d, none expected",
                 res_valid, res_y, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (res_valid !== e.rv || res_y !== e.y || cyc != e.due) begin
          n_err++;
          $display("FAIL result: got res_valid=%b res_y=%h cycle %0d, want %b %h cycle %0d",
                   res_valid, res_y, cyc, e.rv, e.y, e.due);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  function automatic logic [N*32-1:0] pk(input logic [31:0] v0, input logic [31:0] v1,
                                         input logic [31:0] v2, input logic [31:0] v3);
    return {v3, v2, v1, v0};
  endfunction

  // One cycle of stimulus: drive, check grant, push expected result.
  task automatic step(input logic [N-1:0] vld, input logic [N*32-1:0] a_pk,
                      input logic [N*32-1:0] b_pk, input logic fl,
                      input logic [N-1:0] exp_rdy, input logic [63:0] exp_y);
    exp_t e;
    req_valid = vld;
    req_a     = a_pk;
    req_b     = b_pk;
    flush     = fl;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== exp_rdy) begin
      n_err++;
      $display("FAIL grant: got req_ready=%b want %b at cycle %0d", req_ready, exp_rdy, cyc);
    end
    if (exp_rdy != 4'b0000) begin
      e.rv  = exp_rdy;
      e.y   = exp_y;
      e.due = cyc + 1 + LAT;
      exp_q.push_back(e);
    end
    if (fl) exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(4'b0000, '0, '0, 1'b0, 4'b0000, 64'd0);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = 4'b0000;
    flush     = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    ta[0] = 32'h0000_0002; tb[0] = 32'h0000_0003; ty[0] = 64'h0000_0000_0000_0006;
    ta[1] = 32'hFFFF_FFFB; tb[1] = 32'h0000_0004; ty[1] = 64'hFFFF_FFFF_FFFF_FFEC;
    ta[2] = 32'h0001_0000; tb[2] = 32'h0001_0000; ty[2] = 64'h0000_0001_0000_0000;
    ta[3] = 32'h7FFF_FFFF; tb[3] = 32'h7FFF_FFFF; ty[3] = 64'h3FFF_FFFF_0000_0001;

    rst_n     = 1'b0;
    req_valid = 4'b0000;
    req_a     = '0;
    req_b     = '0;
    flush     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_mult_a", 64'(mult_a), 64'd0);
    chk("reset_mult_b", 64'(mult_b), 64'd0);
    chk("reset_res_valid", 64'(res_valid), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single request from requester 2: -3 * 7.
    idle(8);
    step(4'b0100, pk(32'd0, 32'd0, 32'hFFFF_FFFD, 32'd0), pk(32'd0, 32'd0, 32'd7, 32'd0),
         1'b0, 4'b0100, 64'hFFFF_FFFF_FFFF_FFEB);
    chk("busy_after_issue", 64'(busy), 64'd1);
    idle(40);

    // Corner operands on requester 0, back to back.
    step(4'b0001, pk(32'h8000_0000, 0, 0, 0), pk(32'h8000_0000, 0, 0, 0),
         1'b0, 4'b0001, 64'h4000_0000_0000_0000);
    step(4'b0001, pk(32'h8000_0000, 0, 0, 0), pk(32'h0000_0001, 0, 0, 0),
         1'b0, 4'b0001, 64'hFFFF_FFFF_8000_0000);
    step(4'b0001, pk(32'h0000_0000, 0, 0, 0), pk(32'hFFFF_FFFF, 0, 0, 0),
         1'b0, 4'b0001, 64'h0000_0000_0000_0000);
    idle(40);

    // Full contention from reset: grants rotate 0,1,2,3,...
    do_reset();
    for (int k = 0; k < 8; k++)
      step(4'b1111, pk(ta[0], ta[1], ta[2], ta[3]), pk(tb[0], tb[1], tb[2], tb[3]),
           1'b0, 4'b0001 << (k % 4), ty[k % 4]);
    idle(40);

    // Sparse fairness: only 1 and 3 request, they alternate.
    for (int k = 0; k < 6; k++)
      step(4'b1010, pk(ta[0], ta[1], ta[2], ta[3]), pk(tb[0], tb[1], tb[2], tb[3]),
           1'b0, (k % 2 == 0) ? 4'b0010 : 4'b1000, (k % 2 == 0) ? ty[1] : ty[3]);
    idle(40);

    // Flush: five accepts, one flush cycle, then a fresh accept.
    for (int k = 0; k < 5; k++)
      step(4'b0001, pk(ta[0], 0, 0, 0), pk(tb[0], 0, 0, 0), 1'b0, 4'b0001, ty[0]);
    chk("busy_before_flush", 64'(busy), 64'd1);
    step(4'b0001, pk(ta[0], 0, 0, 0), pk(tb[0], 0, 0, 0), 1'b1, 4'b0000, 64'd0);
    chk("busy_after_flush", 64'(busy), 64'd0);
    step(4'b0001, pk(ta[0], 0, 0, 0), pk(32'hFFFF_FFFF, 0, 0, 0), 1'b0, 4'b0001,
         64'hFFFF_FFFF_FFFF_FFFE);
    chk("busy_after_new_accept", 64'(busy), 64'd1);
    idle(40);

    // Asynchronous reset with ten operations in flight.
    for (int k = 0; k < 10; k++)
      step(4'b0001, pk(ta[3], 0, 0, 0), pk(tb[3], 0, 0, 0), 1'b0, 4'b0001, ty[3]);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_res_valid", 64'(res_valid), 64'd0);
    chk("midreset_busy", 64'(busy), 64'd0);
    chk("midreset_mult_a", 64'(mult_a), 64'd0);
    chk("midreset_mult_b", 64'(mult_b), 64'd0);
    exp_q.delete();
    req_valid = 4'b0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset_busy", 64'(busy), 64'd0);
    idle(40);

    chk("all_results_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
